c_tt2_mrcs_latch_seq: RTL and testbench
=======================================

# c_tt2_mrcs_latch_seq

Self-test sequencer for the binary storage cells: `c_BIN_DFF`, `c_BIN_NAND_DLATCH`, `c_BIN_NAND_SR_LATCH` and `c_BIN_ZOOK_DLATCH`.

- Drives a fixed 8-step stimulus program into the selected cell, waits a settle window and compares the cell's `out_0` against a golden value.
- Reports busy, done, pass and fail status, plus the step index, on the tile outputs.
- Sits at tile top level as the next-generation replacement for direct pin-to-cell wiring.
- Lets the latch cells be characterised on silicon from a single clock.

## Interface

Parameters:

- `STEPS`, 8: stimulus steps per run. Fixed by the ROM tables; the step index is 3 bits.
- `SETTLE`, 2: idle cycles between applying stimulus and sampling `out_0`. Range 0–15.

Ports:

- `io_in[0]`, input, 1: clock. Single clock domain, rising edge.
- `io_in[1]`, input, 1: reset. Synchronous, active-high.
- `io_in[2]`, input, 1: `start`, level-sampled.
- `io_in[4:3]`, input, 2: `sel`, the cell under test.
  - 00: DFF.
  - 01: NAND D-latch.
  - 10: NAND SR latch.
  - 11: ZOOK D-latch.
- `io_in[7:5]`, input, 3: unused, ignored.
- `io_out[0]`, output, 1: `busy`.
- `io_out[1]`, output, 1: `done`.
- `io_out[2]`, output, 1: `pass`.
- `io_out[3]`, output, 1: `fail`.
- `io_out[6:4]`, output, 3: `idx`. Current step while running; frozen failing or last step once done.
- `io_out[7]`, output, 1: `obs`, registered `out_0` of the selected cell.

## Operation

States and transitions:

- IDLE: waits for `start=1`.
- APPLY → SETTLE → CHECK, repeated per step.
- CHECK → APPLY for the next step, or → DONE.
- DONE → APPLY (step 0) on `start=1`.

Run start:

- On `start=1` in IDLE or DONE: latch `sel`, clear `pass`, `fail` and `idx`.

APPLY:

- Register stimulus pair (a, b) for step `idx`.
- Every cell receives the same a and b; only the selected cell's `out_0` is checked.

SETTLE:

- Count `SETTLE` cycles.
- With `SETTLE`=0 this state is skipped.

CHECK:

- Sample `out_0` into `obs`.
- If the step is a care step and `obs` ≠ expected: set `fail`, go to DONE, freeze `idx`.
- Else if `idx`=7: set `pass`, go to DONE.
- Else: increment `idx`.

Pin mapping per cell (a, b):

- DFF: a=`in_0` (cell clock), b=`in_1` (D).
- NAND D-latch: a=`in_1` (EN), b=`in_0` (D).
- SR latch: a=`in_0` (S̄), b=`in_1` (R̄).
- ZOOK D-latch: a=`in_2` (EN̄), b=`in_1` (D).

Programs, given as (a, b, exp) per step 0–7:

- DFF: (0,1,x) (1,1,1) (0,0,1) (1,0,0) (0,1,0) (1,1,1) (1,0,1) (0,0,1). Step 0 is don't-care.
- NAND D-latch: (1,1,1) (1,0,0) (0,1,0) (0,0,0) (1,1,1) (0,0,1) (0,1,1) (1,0,0).
- SR latch: (0,1,1) (1,1,1) (1,0,0) (1,1,0) (0,1,1) (1,1,1) (1,0,0) (1,1,0). Never applies (0,0).
- ZOOK D-latch: (0,1,1) (1,0,1) (1,1,1) (0,0,0) (1,1,0) (0,1,1) (1,0,1) (0,0,0).

Boundary conditions:

- `start` while busy: ignored.
- `sel` change mid-run: ignored.
- `start` held high in DONE: immediate restart.
- Reset mid-run: next edge returns to IDLE; all flags cleared.

## Timing

Reset values:

- State IDLE; `busy`, `done`, `pass`, `fail` = 0; `idx`=0; `obs`=0.
- Stimulus a=1, b=1. This is the hold/safe value for every cell.

Latency:

- `start` sampled at edge N → APPLY at N+1.
- Each step takes `SETTLE`+2 cycles.
- Full pass: 8·(`SETTLE`+2) cycles from leaving IDLE to entering DONE; 32 cycles with default `SETTLE`.

Output behaviour:

- `busy`=1 in APPLY, SETTLE and CHECK.
- `done`, `pass` and `fail` are registered and asserted the cycle DONE is entered.
- `pass` and `fail` are mutually exclusive.
- `obs` updates only in CHECK.

## Structure

Package `c_tt2_mrcs_seq_pkg` holds:

- State enum.
- `sel` codes.
- `STEPS`.
- Per-cell stimulus/expect/care tables as constants.

Sub-module `c_tt2_mrcs_stim_rom`:

- Combinational lookup: (`sel`, `idx`) → a, b, exp, care.

Top level:

- Instantiates the four cells unmodified.
- Holds the FSM, the settle counter and the output registers.

## Test plan

- Reset, then `sel`=00, `start` pulse → `busy` for 32 cycles, then `done`=1, `pass`=1, `fail`=0, `idx`=7.
- `sel`=10 with `SETTLE`=0 → completes in 16 cycles, `pass`=1; bench asserts a=b=0 never occurs.
- `sel`=01 with a forced cell output stuck at 0 (bench override) → `fail`=1 at step 0, `idx`=0, `done` 2+`SETTLE` cycles after APPLY.
- Assert reset during step 4 of a `sel`=11 run → next cycle IDLE, all outputs 0, stimulus a=b=1.
- Toggle `start` and `sel` mid-run → run continues on the original `sel`. Then hold `start` high in DONE → a new run begins next cycle with flags cleared.
- All four `sel` values back-to-back → four passes; `obs` matches the expected value at each CHECK.

Source files
------------

// File: rtl/c_tt2_mrcs_seq_pkg.sv
// Shared definitions for the storage-cell self-test sequencer.
//   - state_e : sequencer FSM states
//   - sel_e   : cell-under-test select codes
//   - STEPS   : stimulus steps per run
//   - prog_t  : per-cell stimulus/expect/care tables, bit k = step k
package c_tt2_mrcs_seq_pkg;

  localparam int STEPS = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_APPLY, ST_SETTLE, ST_CHECK, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_DFF = 2'b00,
    SEL_NDL = 2'b01,
    SEL_SR  = 2'b10,
    SEL_ZDL = 2'b11
  } sel_e;

  typedef struct packed {
    logic [STEPS-1:0] a;
    logic [STEPS-1:0] b;
    logic [STEPS-1:0] exp;
    logic [STEPS-1:0] care;
  } prog_t;

  // DFF step 0 has no defined prior state, so it is masked out of care.
  localparam prog_t PROG_DFF = '{a: 8'b0110_1010, b: 8'b0011_0011,
                                 exp: 8'b1110_0110, care: 8'b1111_1110};
  localparam prog_t PROG_NDL = '{a: 8'b1001_0011, b: 8'b0101_0101,
                                 exp: 8'b0111_0001, care: 8'b1111_1111};
  // SR program never drives S_n = R_n = 0.
  localparam prog_t PROG_SR  = '{a: 8'b1110_1110, b: 8'b1011_1011,
                                 exp: 8'b0011_0011, care: 8'b1111_1111};
  localparam prog_t PROG_ZDL = '{a: 8'b0101_0110, b: 8'b0011_0101,
                                 exp: 8'b0110_0111, care: 8'b1111_1111};

endpackage

// File: rtl/c_BIN_DFF.sv
// Rising-edge D flip-flop cell.
//   in_0 : cell clock
//   in_1 : D
//   out_0: Q
module c_BIN_DFF (
  input  logic in_0,
  input  logic in_1,
  output logic out_0
);
  always_ff @(posedge in_0) out_0 <= in_1;
endmodule

// File: rtl/c_BIN_NAND_DLATCH.sv
// Gated D latch built from NAND gates, transparent while EN is high.
//   in_0 : D
//   in_1 : EN
//   out_0: Q
module c_BIN_NAND_DLATCH (
  input  logic in_0,
  input  logic in_1,
  output logic out_0
);
  always_latch begin
    if (in_1) out_0 <= in_0;
  end
endmodule

// File: rtl/c_BIN_NAND_SR_LATCH.sv
// Cross-coupled NAND SR latch with active-low set/reset.
//   in_0 : S_n
//   in_1 : R_n
//   out_0: Q
module c_BIN_NAND_SR_LATCH (
  input  logic in_0,
  input  logic in_1,
  output logic out_0
);
  always_latch begin
    if (!in_0)      out_0 <= 1'b1;
    else if (!in_1) out_0 <= 1'b0;
  end
endmodule

// File: rtl/c_BIN_ZOOK_DLATCH.sv
// D latch with active-low enable, transparent while EN_n is low.
//   in_1 : D
//   in_2 : EN_n
//   out_0: Q
module c_BIN_ZOOK_DLATCH (
  input  logic in_1,
  input  logic in_2,
  output logic out_0
);
  always_latch begin
    if (!in_2) out_0 <= in_1;
  end
endmodule

// File: rtl/c_tt2_mrcs_stim_rom.sv
// Combinational stimulus ROM: (sel, step) -> stimulus pair and golden value.
//   sel_i : cell under test
//   idx_i : step index
//   a_o/b_o : stimulus pair for the step
//   exp_o   : expected out_0 after the step settles
//   care_o  : 1 when exp_o is meaningful
module c_tt2_mrcs_stim_rom
  import c_tt2_mrcs_seq_pkg::*;
(
  input  sel_e       sel_i,
  input  logic [2:0] idx_i,
  output logic       a_o,
  output logic       b_o,
  output logic       exp_o,
  output logic       care_o
);
  prog_t prog;

  always_comb begin
    prog = PROG_DFF;
    case (sel_i)
      SEL_DFF: prog = PROG_DFF;
      SEL_NDL: prog = PROG_NDL;
      SEL_SR:  prog = PROG_SR;
      SEL_ZDL: prog = PROG_ZDL;
      default: prog = PROG_DFF;
    endcase
  end

  assign a_o    = prog.a[idx_i];
  assign b_o    = prog.b[idx_i];
  assign exp_o  = prog.exp[idx_i];
  assign care_o = prog.care[idx_i];
endmodule

// File: rtl/c_tt2_mrcs_latch_seq.sv
// Self-test sequencer for the four binary storage cells.
// Runs an 8-step stimulus program into the selected cell, waits SETTLE
// cycles per step and compares out_0 against the golden value.
//   io_in[0]   clock          io_out[0]   busy
//   io_in[1]   sync reset     io_out[1]   done
//   io_in[2]   start (level)  io_out[2]   pass
//   io_in[4:3] sel            io_out[3]   fail
//   io_in[7:5] unused         io_out[6:4] idx
//                             io_out[7]   obs (sampled out_0)
module c_tt2_mrcs_latch_seq #(
  parameter int STEPS  = 8,
  parameter int SETTLE = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  import c_tt2_mrcs_seq_pkg::*;

  localparam logic [2:0] IDX_LAST = 3'(STEPS - 1);
  localparam logic [3:0] SET_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic clk, rst, start;
  sel_e sel_in;
  logic io_unused;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign start     = io_in[2];
  assign sel_in    = sel_e'(io_in[4:3]);
  assign io_unused = ^io_in[7:5];

  state_e     state_q, state_d;
  sel_e       sel_q, sel_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stim_a_q, stim_a_d, stim_b_q, stim_b_d;
  logic       obs_q, obs_d, pass_q, pass_d, fail_q, fail_d;

  logic rom_a, rom_b, rom_exp, rom_care;
  logic dff_q, ndl_q, sr_q, zdl_q, cell_q;

  c_tt2_mrcs_stim_rom u_rom (
    .sel_i (sel_q),
    .idx_i (idx_q),
    .a_o   (rom_a),
    .b_o   (rom_b),
    .exp_o (rom_exp),
    .care_o(rom_care)
  );

  // All cells see the same (a, b); each maps it onto its own pins.
  c_BIN_DFF           u_dff (.in_0(stim_a_q), .in_1(stim_b_q), .out_0(dff_q));
  c_BIN_NAND_DLATCH   u_ndl (.in_0(stim_b_q), .in_1(stim_a_q), .out_0(ndl_q));
  c_BIN_NAND_SR_LATCH u_sr  (.in_0(stim_a_q), .in_1(stim_b_q), .out_0(sr_q));
  c_BIN_ZOOK_DLATCH   u_zdl (.in_1(stim_b_q), .in_2(stim_a_q), .out_0(zdl_q));

  always_comb begin
    case (sel_q)
      SEL_DFF: cell_q = dff_q;
      SEL_NDL: cell_q = ndl_q;
      SEL_SR:  cell_q = sr_q;
      default: cell_q = zdl_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stim_a_d = stim_a_q;
    stim_b_d = stim_b_q;
    obs_d    = obs_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sel_d   = sel_in;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        stim_a_d = rom_a;
        stim_b_d = rom_b;
        cnt_d    = '0;
        state_d  = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) state_d = ST_CHECK;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_CHECK: begin
        obs_d = cell_q;
        if (rom_care && (cell_q != rom_exp)) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else if (idx_q == IDX_LAST) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_DFF;
      idx_q    <= '0;
      cnt_q    <= '0;
      stim_a_q <= 1'b1;   // (1,1) holds every cell
      stim_b_q <= 1'b1;
      obs_q    <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      stim_a_q <= stim_a_d;
      stim_b_q <= stim_b_d;
      obs_q    <= obs_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  logic busy, done;
  assign busy = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done = (state_q == ST_DONE);

  assign io_out = {obs_q, idx_q, fail_q, pass_q, done, busy};
endmodule

// File: tb/tb_c_tt2_mrcs_latch_seq.sv
// Bench for c_tt2_mrcs_latch_seq: one instance with SETTLE=2, one with
// SETTLE=0. Expected values come from the step tables and the step-length
// arithmetic (SETTLE+2 cycles per step).
module tb_c_tt2_mrcs_latch_seq;
  localparam int SA = 2;
  localparam int SB = 0;

  // (a, b, exp) per step; exp = -1 means don't care.
  localparam int PROG [4][8][3] = '{
    '{'{0,1,-1},'{1,1,1},'{0,0,1},'{1,0,0},'{0,1,0},'{1,1,1},'{1,0,1},'{0,0,1}},
    '{'{1,1,1},'{1,0,0},'{0,1,0},'{0,0,0},'{1,1,1},'{0,0,1},'{0,1,1},'{1,0,0}},
    '{'{0,1,1},'{1,1,1},'{1,0,0},'{1,1,0},'{0,1,1},'{1,1,1},'{1,0,0},'{1,1,0}},
    '{'{0,1,1},'{1,0,1},'{1,1,1},'{0,0,0},'{1,1,0},'{0,1,1},'{1,0,1},'{0,0,0}}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_v [2];
  logic [7:0] io_in_a, io_in_b, io_out_a, io_out_b;
  assign io_in_a = {in_v[0][7:1], clk};
  assign io_in_b = {in_v[1][7:1], clk};

  c_tt2_mrcs_latch_seq #(.STEPS(8), .SETTLE(SA)) dut  (.io_in(io_in_a), .io_out(io_out_a));
  c_tt2_mrcs_latch_seq #(.STEPS(8), .SETTLE(SB)) dut0 (.io_in(io_in_b), .io_out(io_out_b));

  int n_cmp = 0;
  int n_bad = 0;

  // dut0 only ever runs the SR program, so any (0,0) here is illegal.
  bit sr_zero_seen = 1'b0;
  always @(negedge clk) if (dut0.stim_a_q == 1'b0 && dut0.stim_b_q == 1'b0) sr_zero_seen <= 1'b1;

  function automatic logic [7:0] prog_bits(input int s, input int f);
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++)
      if (f == 3) v[k] = (PROG[s][k][2] >= 0);
      else        v[k] = (PROG[s][k][f] == 1);
    return v;
  endfunction

  function automatic int step_len(input int w);
    return (w == 0 ? SA : SB) + 2;
  endfunction

  function automatic logic [7:0] get_out(input int w);
    return (w == 0) ? io_out_a : io_out_b;
  endfunction

  function automatic logic [1:0] get_stim(input int w);
    return (w == 0) ? {dut.stim_a_q, dut.stim_b_q} : {dut0.stim_a_q, dut0.stim_b_q};
  endfunction

  // Starts a run from IDLE/DONE and records outputs until done or a bound.
  task automatic run_prog(input int w, input logic [1:0] sel, input bit toggle,
                          output int cyc, output logic [7:0] first_out,
                          output logic [7:0] last_out, output logic [7:0] obs_at,
                          output logic [7:0] sa, output logic [7:0] sb,
                          output int busy_gaps);
    int L;
    logic [1:0] st;
    L = step_len(w);
    obs_at = '0; sa = '0; sb = '0; busy_gaps = 0;
    in_v[w] = {3'($urandom), sel, 1'b1, 1'b0, 1'b0};
    @(posedge clk); @(negedge clk);
    cyc = 0;
    first_out = get_out(w);
    last_out = first_out;
    while (last_out[1] !== 1'b1 && cyc < 400) begin
      in_v[w][2] = toggle ? 1'($urandom) : 1'b0;
      if (toggle) in_v[w][4:3] = 2'($urandom);
      in_v[w][7:5] = 3'($urandom);
      @(posedge clk); @(negedge clk);
      cyc++;
      last_out = get_out(w);
      if (last_out[1] !== 1'b1 && last_out[0] !== 1'b1) busy_gaps++;
      for (int k = 0; k < 8; k++) begin
        if (cyc == k * L + 1) begin st = get_stim(w); sa[k] = st[1]; sb[k] = st[0]; end
        if (cyc == (k + 1) * L) obs_at[k] = last_out[7];
      end
    end
    in_v[w][2] = 1'b0;
  endtask

  task automatic test_reset();
    in_v[0] = 8'h02; in_v[1] = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (io_out_a !== 8'h00) begin n_bad++; $display("FAIL reset_out_a: got %h want 00", io_out_a); end
    n_cmp++; if (io_out_b !== 8'h00) begin n_bad++; $display("FAIL reset_out_b: got %h want 00", io_out_b); end
    n_cmp++; if (get_stim(0) !== 2'b11) begin n_bad++; $display("FAIL reset_stim: got %b want 11", get_stim(0)); end
    in_v[0] = 8'h00; in_v[1] = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_dff_pass();
    int cyc, gaps;
    logic [7:0] f, l, o, a, b, care, ex;
    run_prog(0, 2'b00, 1'b0, cyc, f, l, o, a, b, gaps);
    care = prog_bits(0, 3); ex = prog_bits(0, 2);
    n_cmp++; if (cyc !== 8 * step_len(0)) begin n_bad++; $display("FAIL dff_cycles: got %0d want %0d", cyc, 8 * step_len(0)); end
    n_cmp++; if (l !== {ex[7], 3'd7, 4'b0110}) begin n_bad++; $display("FAIL dff_final: got %h want %h", l, {ex[7], 3'd7, 4'b0110}); end
    n_cmp++; if (gaps !== 0 || f[3:0] !== 4'b0001) begin n_bad++; $display("FAIL dff_busy: got gaps %0d first %h want 0 / x1", gaps, f); end
    n_cmp++; if ({a, b} !== {prog_bits(0, 0), prog_bits(0, 1)}) begin n_bad++; $display("FAIL dff_stim: got %h%h want %h%h", a, b, prog_bits(0, 0), prog_bits(0, 1)); end
    n_cmp++; if ((o & care) !== (ex & care)) begin n_bad++; $display("FAIL dff_obs: got %b want %b", o & care, ex & care); end
  endtask

  task automatic test_sr_settle0();
    int cyc, gaps;
    logic [7:0] f, l, o, a, b, ex;
    run_prog(1, 2'b10, 1'b0, cyc, f, l, o, a, b, gaps);
    ex = prog_bits(2, 2);
    n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL sr_cycles: got %0d want 16", cyc); end
    n_cmp++; if (l !== {ex[7], 3'd7, 4'b0110}) begin n_bad++; $display("FAIL sr_final: got %h want %h", l, {ex[7], 3'd7, 4'b0110}); end
    n_cmp++; if ({a, b} !== {prog_bits(2, 0), prog_bits(2, 1)}) begin n_bad++; $display("FAIL sr_stim: got %h%h want %h%h", a, b, prog_bits(2, 0), prog_bits(2, 1)); end
    n_cmp++; if (o !== ex) begin n_bad++; $display("FAIL sr_obs: got %b want %b", o, ex); end
    n_cmp++; if (sr_zero_seen !== 1'b0) begin n_bad++; $display("FAIL sr_no_00: got %b want 0", sr_zero_seen); end
  endtask

  task automatic test_fail_forced();
    int cyc, gaps, kf;
    logic [7:0] f, l, o, a, b, care, ex;
    care = prog_bits(1, 3); ex = prog_bits(1, 2);
    kf = -1;
    for (int k = 7; k >= 0; k--) if (care[k] && ex[k] != 1'b0) kf = k;
    force dut.ndl_q = 1'b0;
    run_prog(0, 2'b01, 1'b0, cyc, f, l, o, a, b, gaps);
    release dut.ndl_q;
    n_cmp++; if (cyc !== (kf + 1) * step_len(0)) begin n_bad++; $display("FAIL stuck_cycles: got %0d want %0d", cyc, (kf + 1) * step_len(0)); end
    n_cmp++; if (l !== {1'b0, 3'(kf), 4'b1010}) begin n_bad++; $display("FAIL stuck_final: got %h want %h", l, {1'b0, 3'(kf), 4'b1010}); end
    in_v[0] = 8'h02;
    @(posedge clk); @(negedge clk);
    in_v[0] = 8'h00;
  endtask

  task automatic test_reset_mid();
    in_v[0] = {3'($urandom), 2'b11, 1'b1, 1'b0, 1'b0};
    @(posedge clk); @(negedge clk);
    in_v[0][2] = 1'b0;
    repeat (4 * step_len(0) + 1) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (io_out_a[6:4] !== 3'd4 || io_out_a[0] !== 1'b1) begin n_bad++; $display("FAIL midrun_step: got %h want idx 4 busy", io_out_a); end
    in_v[0][1] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (io_out_a !== 8'h00) begin n_bad++; $display("FAIL midrun_reset_out: got %h want 00", io_out_a); end
    n_cmp++; if (get_stim(0) !== 2'b11) begin n_bad++; $display("FAIL midrun_reset_stim: got %b want 11", get_stim(0)); end
    in_v[0] = 8'h00;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (io_out_a !== 8'h00) begin n_bad++; $display("FAIL midrun_idle: got %h want 00", io_out_a); end
  endtask

  task automatic test_toggle_hold();
    int cyc, gaps, sa_i, sb_i;
    logic [7:0] f, l, o, a, b, ex;
    sa_i = int'($urandom_range(0, 3));
    sb_i = (sa_i + int'($urandom_range(1, 3))) % 4;
    run_prog(0, 2'(sa_i), 1'b1, cyc, f, l, o, a, b, gaps);
    ex = prog_bits(sa_i, 2);
    n_cmp++; if (cyc !== 8 * step_len(0) || l[6:0] !== {3'd7, 4'b0110}) begin n_bad++; $display("FAIL toggle_run: got cyc %0d out %h want %0d / 7 pass", cyc, l, 8 * step_len(0)); end
    n_cmp++; if ({a, b} !== {prog_bits(sa_i, 0), prog_bits(sa_i, 1)}) begin n_bad++; $display("FAIL toggle_sel_kept: got %h%h want %h%h", a, b, prog_bits(sa_i, 0), prog_bits(sa_i, 1)); end
    // start is raised while in DONE: the next edge must already be APPLY
    run_prog(0, 2'(sb_i), 1'b0, cyc, f, l, o, a, b, gaps);
    n_cmp++; if (f[6:0] !== 7'b000_0001) begin n_bad++; $display("FAIL hold_restart: got %h want busy, flags clear, idx 0", f[6:0]); end
    n_cmp++; if (l[6:0] !== {3'd7, 4'b0110} || {a, b} !== {prog_bits(sb_i, 0), prog_bits(sb_i, 1)}) begin n_bad++; $display("FAIL hold_run: got out %h stim %h%h want 7 pass on sel %0d", l, a, b, sb_i); end
  endtask

  task automatic test_back_to_back();
    int order [4];
    int cyc, gaps, j, t;
    logic [7:0] f, l, o, a, b, care, ex;
    for (int i = 0; i < 4; i++) order[i] = i;
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 4; i++) begin
      run_prog(0, 2'(order[i]), 1'b0, cyc, f, l, o, a, b, gaps);
      care = prog_bits(order[i], 3); ex = prog_bits(order[i], 2);
      n_cmp++; if (cyc !== 8 * step_len(0)) begin n_bad++; $display("FAIL b2b_cycles sel %0d: got %0d want %0d", order[i], cyc, 8 * step_len(0)); end
      n_cmp++; if (l !== {ex[7], 3'd7, 4'b0110}) begin n_bad++; $display("FAIL b2b_final sel %0d: got %h want %h", order[i], l, {ex[7], 3'd7, 4'b0110}); end
      n_cmp++; if ((o & care) !== (ex & care)) begin n_bad++; $display("FAIL b2b_obs sel %0d: got %b want %b", order[i], o & care, ex & care); end
      n_cmp++; if (f[3:0] !== 4'b0001 || gaps !== 0) begin n_bad++; $display("FAIL b2b_busy sel %0d: got first %h gaps %0d want busy", order[i], f, gaps); end
    end
  endtask

  initial begin
    in_v[0] = 8'h02; in_v[1] = 8'h02;
    test_reset();
    test_dff_pass();
    test_sr_settle0();
    test_fail_forced();
    test_reset_mid();
    test_toggle_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
